// File: rtl/wb_stage.sv
// wb_stage: load alignment, result select, 32-entry GPR file with write-first bypass, forwarding tap and commit counter
module wb_stage #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FUNCT3_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      gpr_en_wb,
  input  logic                      gpr_we_wb,
  input  logic [REG_ADDR_WIDTH-1:0] addr_rd_wb,
  input  logic [REG_WIDTH-1:0]      data_rd_wb,
  input  logic [REG_WIDTH-1:0]      data_rd_wb_mem,
  input  logic [FUNCT3_WIDTH-1:0]   funct3_mem_wb,
  input  logic                      mem_mem_wb,
  input  logic [1:0]                byte_off_wb,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic [REG_WIDTH-1:0]      rs1_data,
  output logic [REG_WIDTH-1:0]      rs2_data,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [REG_WIDTH-1:0]      fwd_data,
  output logic [31:0]               commit_cnt
);
  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  logic [REG_WIDTH-1:0] r_gpr [NREG];
  logic [31:0]          r_commit_cnt;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [REG_WIDTH-1:0] w_load;
  logic [REG_WIDTH-1:0] w_wb_data;
  logic                 w_commit;
  // Extract the addressed lane and extend it; funct3[2] selects zero-extension, low bits select width
  always_comb begin
    w_byte = data_rd_wb_mem[8*byte_off_wb +: 8];
    w_half = byte_off_wb[1] ? data_rd_wb_mem[31:16] : data_rd_wb_mem[15:0];
    w_load = funct3_mem_wb[1:0] == 2'b00 ? {{(REG_WIDTH-8){w_byte[7] & ~funct3_mem_wb[2]}}, w_byte} :
             funct3_mem_wb[1:0] == 2'b01 ? {{(REG_WIDTH-16){w_half[15] & ~funct3_mem_wb[2]}}, w_half} :
             data_rd_wb_mem;
    w_wb_data = mem_mem_wb ? w_load : data_rd_wb;
    w_commit  = gpr_en_wb & gpr_we_wb & (addr_rd_wb != '0) & ~rst;
  end
  // Read ports: x0 is hardwired zero, an in-flight commit to the same register wins over the array
  always_comb begin
    rs1_data = rs1_addr == '0 ? '0 : (w_commit && rs1_addr == addr_rd_wb) ? w_wb_data : r_gpr[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : (w_commit && rs2_addr == addr_rd_wb) ? w_wb_data : r_gpr[rs2_addr];
    fwd_valid = w_commit;
    fwd_addr  = addr_rd_wb;
    fwd_data  = w_wb_data;
  end
  // Register file update; reset clears every entry and drops any write presented alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
    end else if (w_commit) begin
      r_gpr[addr_rd_wb] <= w_wb_data;
    end
  end
  // Count committed writes, wrapping naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) r_commit_cnt <= '0;
    else if (w_commit) r_commit_cnt <= r_commit_cnt + 32'd1;
  end
  assign commit_cnt = r_commit_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven, directed and randomized checks of wb_stage against a behavioural model
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        gpr_en_wb, gpr_we_wb, mem_mem_wb;
  logic [4:0]  addr_rd_wb, rs1_addr, rs2_addr, fwd_addr;
  logic [31:0] data_rd_wb, data_rd_wb_mem, rs1_data, rs2_data, fwd_data, commit_cnt;
  logic [2:0]  funct3_mem_wb;
  logic [1:0]  byte_off_wb;
  logic        fwd_valid;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_gpr [32];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .gpr_en_wb(gpr_en_wb), .gpr_we_wb(gpr_we_wb),
    .addr_rd_wb(addr_rd_wb), .data_rd_wb(data_rd_wb), .data_rd_wb_mem(data_rd_wb_mem),
    .funct3_mem_wb(funct3_mem_wb), .mem_mem_wb(mem_mem_wb), .byte_off_wb(byte_off_wb),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .commit_cnt(commit_cnt)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] raw;
    logic [31:0] exp;
  } load_vec_t;

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] off, input logic [31:0] raw);
    longint unsigned b, h;
    b = (longint'(raw) >> (8 * off)) % 256;
    h = (longint'(raw) >> (16 * off[1])) % 65536;
    case (f)
      3'd0: return b >= 128 ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd4: return 32'(b);
      3'd1: return h >= 32768 ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd5: return 32'(h);
      default: return raw;
    endcase
  endfunction

  function automatic logic m_commit();
    return gpr_en_wb && gpr_we_wb && addr_rd_wb != 0 && !rst;
  endfunction

  function automatic logic [31:0] m_wb();
    return mem_mem_wb ? ref_load(funct3_mem_wb, byte_off_wb, data_rd_wb_mem) : data_rd_wb;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (m_commit() && a == addr_rd_wb) return m_wb();
    return m_gpr[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_w(input logic en, input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mem, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] raw);
    gpr_en_wb = en; gpr_we_wb = we; addr_rd_wb = rd; data_rd_wb = d;
    mem_mem_wb = mem; funct3_mem_wb = f3; byte_off_wb = off; data_rd_wb_mem = raw;
  endtask

  task automatic idle();
    set_w(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd2, 2'd0, 32'd0);
  endtask

  task automatic check_now();
    #1;
    chk("rs1_data", rs1_data, m_read(rs1_addr));
    chk("rs2_data", rs2_data, m_read(rs2_addr));
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, m_commit()});
    if (m_commit()) begin
      chk("fwd_addr", {27'd0, fwd_addr}, {27'd0, addr_rd_wb});
      chk("fwd_data", fwd_data, m_wb());
    end
    chk("commit_cnt", commit_cnt, m_cnt);
  endtask

  task automatic tick();
    logic c;
    logic [31:0] w;
    c = m_commit();
    w = m_wb();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (c) begin
      m_gpr[addr_rd_wb] = w;
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    load_vec_t lv [10];
    logic [31:0] cnt0;
    lv[0] = '{3'd0, 2'd2, 32'h1285_3456, 32'hFFFF_FF85};
    lv[1] = '{3'd4, 2'd2, 32'h1285_3456, 32'h0000_0085};
    lv[2] = '{3'd1, 2'd2, 32'h1285_3456, 32'h0000_1285};
    lv[3] = '{3'd5, 2'd2, 32'h8001_0000, 32'h0000_8001};
    lv[4] = '{3'd1, 2'd0, 32'h1234_8765, 32'hFFFF_8765};
    lv[5] = '{3'd1, 2'd3, 32'hF000_0001, 32'hFFFF_F000};
    lv[6] = '{3'd0, 2'd0, 32'h0000_007F, 32'h0000_007F};
    lv[7] = '{3'd0, 2'd3, 32'h80FF_FFFF, 32'hFFFF_FF80};
    lv[8] = '{3'd2, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE};
    lv[9] = '{3'd7, 2'd2, 32'h1357_9BDF, 32'h1357_9BDF};
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'hX;
    m_cnt = 32'hX;
    rst = 1'b1; rs1_addr = 0; rs2_addr = 0;
    idle();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      chk("reset_rs1", rs1_data, 32'd0);
      chk("reset_rs2", rs2_data, 32'd0);
    end
    chk("reset_cnt", commit_cnt, 32'd0);
    chk("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    // table of load alignment vectors, written to x5 and read back through bypass and array
    for (int i = 0; i < 10; i++) begin
      set_w(1'b1, 1'b1, 5'd5, 32'h5555_AAAA, 1'b1, lv[i].f3, lv[i].off, lv[i].raw);
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      check_now();
      chk("load_bypass", rs1_data, lv[i].exp);
      tick();
      idle();
      check_now();
      chk("load_array", rs1_data, lv[i].exp);
    end
    // non-load write with both ports bypassing the same register
    cnt0 = m_cnt;
    set_w(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd2, 32'h0);
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    check_now();
    chk("alu_bypass_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("alu_bypass_rs2", rs2_data, 32'hDEAD_BEEF);
    chk("alu_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    chk("alu_fwd_addr", {27'd0, fwd_addr}, 32'd7);
    tick();
    idle();
    check_now();
    chk("alu_array_rs1", rs1_data, 32'hDEAD_BEEF);
    chk("alu_idle_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("alu_cnt", commit_cnt, cnt0 + 32'd1);
    // write to x0 and disabled write to x3
    cnt0 = m_cnt;
    set_w(1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, 3'd2, 2'd0, 32'h0);
    rs1_addr = 5'd0; rs2_addr = 5'd3;
    check_now();
    chk("x0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    tick();
    set_w(1'b1, 1'b0, 5'd3, 32'h7777, 1'b0, 3'd2, 2'd0, 32'h0);
    check_now();
    chk("x0_read", rs1_data, 32'd0);
    chk("we0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    tick();
    idle();
    check_now();
    chk("we0_x3", rs2_data, 32'd0);
    chk("x0_cnt", commit_cnt, cnt0);
    // back-to-back writes to x9
    cnt0 = m_cnt;
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    set_w(1'b1, 1'b1, 5'd9, 32'd1, 1'b0, 3'd2, 2'd0, 32'h0);
    check_now();
    chk("b2b_c1", rs1_data, 32'd1);
    tick();
    set_w(1'b1, 1'b1, 5'd9, 32'd2, 1'b0, 3'd2, 2'd0, 32'h0);
    check_now();
    chk("b2b_c2", rs1_data, 32'd2);
    tick();
    idle();
    check_now();
    chk("b2b_after", rs1_data, 32'd2);
    chk("b2b_cnt", commit_cnt, cnt0 + 32'd2);
    // reset in the same cycle as a write to x4
    set_w(1'b1, 1'b1, 5'd4, 32'hABCD_0123, 1'b0, 3'd2, 2'd0, 32'h0);
    rs1_addr = 5'd4; rs2_addr = 5'd7;
    rst = 1'b1;
    check_now();
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    check_now();
    chk("rst_x4", rs1_data, 32'd0);
    chk("rst_x7", rs2_data, 32'd0);
    chk("rst_cnt", commit_cnt, 32'd0);
    // randomized traffic with occasional mid-stream reset
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 49) == 0;
      set_w($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom);
      rs1_addr = $urandom_range(0, 2) == 0 ? addr_rd_wb : 5'($urandom_range(0, 31));
      rs2_addr = $urandom_range(0, 2) == 0 ? addr_rd_wb : 5'($urandom_range(0, 31));
      check_now();
      tick();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      check_now();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
